// File: rtl/store_ctrl_if.sv
`default_nettype none
// ============================================================
// Module   : store_ctrl_if
// Desc     : Store request and data-memory write-port bundle
// Revision : 1.0
// ============================================================
interface store_ctrl_if;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [2:0]  st_funct3_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic        busy_o;
  logic        misalign_o;

  modport slave (
    input  st_valid_i, st_funct3_i, st_addr_i, st_data_i, mem_ack_i,
    output st_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           busy_o, misalign_o
  );

  modport master (
    output st_valid_i, st_funct3_i, st_addr_i, st_data_i, mem_ack_i,
    input  st_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           busy_o, misalign_o
  );
endinterface
`default_nettype wire

// File: rtl/store_ctrl.sv
`default_nettype none
// ============================================================
// Module   : store_ctrl
// Desc     : Store queue + byte-lane write-beat sequencer
// Options  : STORE_SPLIT_EN splits word-crossing stores in two beats
// Revision : 1.0
// ============================================================
module store_ctrl #(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         reset,
  store_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW-1:0] head;
  logic          full, empty, accept, legal, enq, pop, split_head;
  logic [1:0]    off;
  logic [3:0]    mask;
  logic [31:0]   data_m;
  logic [3:0]    be0_in;
  logic [31:0]   wd0_in;

  logic [29:0]   q_waddr [DEPTH];
  logic [3:0]    q_be0   [DEPTH];
  logic [31:0]   q_wd0   [DEPTH];

  assign off    = bus.st_addr_i[1:0];
  assign legal  = (bus.st_funct3_i[2] == 1'b0) && (bus.st_funct3_i[1:0] != 2'b11);
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accept = bus.st_valid_i & ~full;
  assign head   = rd_ptr[AW-1:0];

  assign bus.st_ready_o = ~full;
  assign bus.mem_we_o   = (state != S_IDLE);
  assign bus.busy_o     = ~empty | (state != S_IDLE);

  always_comb begin
    mask   = 4'b0000;
    data_m = 32'h0;
    case (bus.st_funct3_i)
      3'b000:  begin mask = 4'b0001; data_m = {24'h0, bus.st_data_i[7:0]};  end
      3'b001:  begin mask = 4'b0011; data_m = {16'h0, bus.st_data_i[15:0]}; end
      3'b010:  begin mask = 4'b1111; data_m = bus.st_data_i;                end
      default: ;
    endcase
  end

`ifdef STORE_SPLIT_EN
  logic [7:0]  lanes;
  logic [63:0] dshift;
  logic        q_split [DEPTH];
  logic [3:0]  q_be1   [DEPTH];
  logic [31:0] q_wd1   [DEPTH];

  assign lanes          = {4'b0000, mask} << off;
  assign dshift         = {32'h0, data_m} << {off, 3'b000};
  assign be0_in         = lanes[3:0];
  assign wd0_in         = dshift[31:0];
  assign enq            = accept & legal;
  assign split_head     = q_split[head];
  assign bus.misalign_o = 1'b0;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_split[wr_ptr[AW-1:0]] <= |lanes[7:4];
      q_be1[wr_ptr[AW-1:0]]   <= lanes[7:4];
      q_wd1[wr_ptr[AW-1:0]]   <= dshift[63:32];
    end
  end
`else
  logic misaligned, misalign_q;

  // Without splitting, any store that would reach past its word is refused.
  assign misaligned     = ((bus.st_funct3_i == 3'b001) && bus.st_addr_i[0]) ||
                          ((bus.st_funct3_i == 3'b010) && (off != 2'b00));
  assign be0_in         = mask << off;
  assign wd0_in         = data_m << {off, 3'b000};
  assign enq            = accept & legal & ~misaligned;
  assign split_head     = 1'b0;
  assign bus.misalign_o = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= accept & legal & misaligned;
  end
`endif

  assign pop = bus.mem_ack_i &
               (((state == S_BEAT0) & ~split_head) | (state == S_BEAT1));

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, enq};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (enq) begin
      q_waddr[wr_ptr[AW-1:0]] <= bus.st_addr_i[31:2];
      q_be0[wr_ptr[AW-1:0]]   <= be0_in;
      q_wd0[wr_ptr[AW-1:0]]   <= wd0_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_BEAT0;
      S_BEAT0: if (bus.mem_ack_i) begin
        if (split_head) state_nxt = S_BEAT1;
        else            state_nxt = (wr_ptr_nxt != rd_ptr_nxt) ? S_BEAT0 : S_IDLE;
      end
      S_BEAT1: if (bus.mem_ack_i)
        state_nxt = (wr_ptr_nxt != rd_ptr_nxt) ? S_BEAT0 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Beat fields come straight from the head entry, so they hold while ack is low.
  always_comb begin
    bus.mem_addr_o  = 32'h0;
    bus.mem_be_o    = 4'b0000;
    bus.mem_wdata_o = 32'h0;
    case (state)
      S_BEAT0: begin
        bus.mem_addr_o  = {q_waddr[head], 2'b00};
        bus.mem_be_o    = q_be0[head];
        bus.mem_wdata_o = q_wd0[head];
      end
`ifdef STORE_SPLIT_EN
      S_BEAT1: begin
        bus.mem_addr_o  = {q_waddr[head] + 30'd1, 2'b00};
        bus.mem_be_o    = q_be1[head];
        bus.mem_wdata_o = q_wd1[head];
      end
`endif
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_store_ctrl.sv
`default_nettype none
// ============================================================
// Module   : tb_store_ctrl
// Desc     : Directed vector bench for store_ctrl
// Revision : 1.0
// ============================================================
module tb_store_ctrl;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  store_ctrl_if bus ();

  store_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          nbeats;
    logic        mis;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [3:0]  be1;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid_i  = 1'b1;
    bus.st_funct3_i = f3;
    bus.st_addr_i   = addr;
    bus.st_data_i   = data;
    step();
    bus.st_valid_i  = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] w);
    chk({tag, "_we"},    32'(bus.mem_we_o), 32'd1);
    chk({tag, "_addr"},  bus.mem_addr_o, a);
    chk({tag, "_be"},    32'(bus.mem_be_o), 32'(be));
    chk({tag, "_wdata"}, bus.mem_wdata_o, w);
  endtask

  logic [31:0] seen [8];
  int          nb, first, last, idx;
  logic        acc;

  initial begin
    vt[0] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 4'h0};
    vt[1] = '{3'b000, 32'h0000_0203, 32'h0000_00A5, 1, 1'b0, 32'h200, 32'hA500_0000, 4'h8, 32'h0, 32'h0, 4'h0};
    vt[2] = '{3'b001, 32'h0000_0302, 32'hFFFF_1234, 1, 1'b0, 32'h300, 32'h1234_0000, 4'hC, 32'h0, 32'h0, 4'h0};
    vt[3] = '{3'b000, 32'h0000_0001, 32'h1234_5677, 1, 1'b0, 32'h000, 32'h0000_7700, 4'h2, 32'h0, 32'h0, 4'h0};
    vt[4] = '{3'b011, 32'h0000_0700, 32'h5555_5555, 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vt[5] = '{3'b010, 32'hFFFF_FFFC, 32'h0102_0304, 1, 1'b0, 32'hFFFF_FFFC, 32'h0102_0304, 4'hF, 32'h0, 32'h0, 4'h0};
`ifdef STORE_SPLIT_EN
    vt[6] = '{3'b010, 32'h0000_0501, 32'h1122_3344, 2, 1'b0, 32'h500, 32'h2233_4400, 4'hE, 32'h504, 32'h0000_0011, 4'h1};
    vt[7] = '{3'b001, 32'h0000_0303, 32'h0000_1234, 2, 1'b0, 32'h300, 32'h3400_0000, 4'h8, 32'h304, 32'h0000_0012, 4'h1};
    vt[8] = '{3'b010, 32'h0000_0402, 32'hAABB_CCDD, 2, 1'b0, 32'h400, 32'hCCDD_0000, 4'hC, 32'h404, 32'h0000_AABB, 4'h3};
    vt[9] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 1'b0, 32'hFFFF_FFFC, 32'hEF00_0000, 4'h8, 32'h0, 32'h0000_00BE, 4'h1};
`else
    vt[6] = '{3'b010, 32'h0000_0501, 32'h1122_3344, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vt[7] = '{3'b001, 32'h0000_0303, 32'h0000_1234, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vt[8] = '{3'b010, 32'h0000_0402, 32'hAABB_CCDD, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vt[9] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
`endif

    reset           = 1'b1;
    bus.st_valid_i  = 1'b0;
    bus.st_funct3_i = 3'b000;
    bus.st_addr_i   = 32'h0;
    bus.st_data_i   = 32'h0;
    bus.mem_ack_i   = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_we",       32'(bus.mem_we_o),   32'd0);
    chk("rst_addr",     bus.mem_addr_o,      32'h0);
    chk("rst_wdata",    bus.mem_wdata_o,     32'h0);
    chk("rst_be",       32'(bus.mem_be_o),   32'd0);
    chk("rst_misalign", 32'(bus.misalign_o), 32'd0);
    chk("rst_busy",     32'(bus.busy_o),     32'd0);
    chk("rst_ready",    32'(bus.st_ready_o), 32'd1);

    // Single stores with ack tied high: one idle cycle after accept, then the beat(s).
    bus.mem_ack_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(bus.st_ready_o), 32'd1);
      push(vt[i].f3, vt[i].addr, vt[i].data);
      chk($sformatf("v%0d_mis", i), 32'(bus.misalign_o), 32'(vt[i].mis));
      chk($sformatf("v%0d_lat_we", i), 32'(bus.mem_we_o), 32'd0);
      if (vt[i].nbeats == 0) begin
        chk($sformatf("v%0d_empty_busy", i), 32'(bus.busy_o), 32'd0);
        step();
        chk($sformatf("v%0d_mis_end", i), 32'(bus.misalign_o), 32'd0);
        chk($sformatf("v%0d_no_we", i), 32'(bus.mem_we_o), 32'd0);
      end else begin
        chk($sformatf("v%0d_busy", i), 32'(bus.busy_o), 32'd1);
        step();
        chk_beat($sformatf("v%0d_b0", i), vt[i].a0, vt[i].be0, vt[i].w0);
        if (vt[i].nbeats == 2) begin
          step();
          chk_beat($sformatf("v%0d_b1", i), vt[i].a1, vt[i].be1, vt[i].w1);
        end
        step();
        chk($sformatf("v%0d_done_we", i), 32'(bus.mem_we_o), 32'd0);
        chk($sformatf("v%0d_done_busy", i), 32'(bus.busy_o), 32'd0);
      end
    end

    // Backpressure: fill the queue with ack low, then drain in order.
    bus.mem_ack_i   = 1'b0;
    bus.st_funct3_i = 3'b010;
    for (int k = 0; k < DEPTH; k++) begin
      bus.st_valid_i = 1'b1;
      bus.st_addr_i  = 32'h800 + 32'(4 * k);
      bus.st_data_i  = 32'(k + 1);
      chk($sformatf("bp_ready%0d", k), 32'(bus.st_ready_o), 32'd1);
      step();
    end
    bus.st_addr_i = 32'h800 + 32'(4 * DEPTH);
    bus.st_data_i = 32'(DEPTH + 1);
    chk("bp_full", 32'(bus.st_ready_o), 32'd0);
    step();
    step();
    chk("bp_stall_ready", 32'(bus.st_ready_o), 32'd0);
    chk_beat("bp_stall", 32'h800, 4'hF, 32'd1);
    bus.mem_ack_i = 1'b1;
    step();
    chk_beat("bp_d1", 32'h804, 4'hF, 32'd2);
    chk("bp_reready", 32'(bus.st_ready_o), 32'd1);
    step();
    bus.st_valid_i = 1'b0;
    chk_beat("bp_d2", 32'h808, 4'hF, 32'd3);
    step();
    chk("bp_end_we", 32'(bus.mem_we_o), 32'd0);
    chk("bp_end_busy", 32'(bus.busy_o), 32'd0);

    // Streaming with ack high: three stores, beats must be back to back.
    nb = 0; first = -1; last = -1; idx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.st_valid_i = (idx < 3);
      bus.st_addr_i  = 32'hA00 + 32'(4 * idx);
      bus.st_data_i  = 32'hC0 + 32'(idx);
      acc = bus.st_valid_i & bus.st_ready_o;
      step();
      if (acc) idx++;
      if (bus.mem_we_o && nb < 8) begin
        seen[nb] = bus.mem_addr_o;
        nb++;
        if (first < 0) first = c;
        last = c;
      end
    end
    bus.st_valid_i = 1'b0;
    chk("st_nbeats", 32'(nb), 32'd3);
    chk("st_span", 32'(last - first), 32'd2);
    for (int j = 0; j < 3; j++)
      chk($sformatf("st_order%0d", j), seen[j], 32'hA00 + 32'(4 * j));

    // Reset while a beat is outstanding and the queue holds two entries.
    bus.mem_ack_i = 1'b0;
`ifdef STORE_SPLIT_EN
    push(3'b001, 32'h303, 32'h1234);
    push(3'b010, 32'h900, 32'h9);
    chk("rs_b0_be", 32'(bus.mem_be_o), 32'h8);
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    chk_beat("rs_b1", 32'h304, 4'h1, 32'h12);
`else
    push(3'b010, 32'h900, 32'h9);
    push(3'b010, 32'h904, 32'hA);
    chk_beat("rs_b0", 32'h900, 4'hF, 32'h9);
`endif
    reset = 1'b1;
    step();
    chk("rs_we",    32'(bus.mem_we_o),   32'd0);
    chk("rs_busy",  32'(bus.busy_o),     32'd0);
    chk("rs_ready", 32'(bus.st_ready_o), 32'd1);
    reset = 1'b0;
    bus.mem_ack_i = 1'b1;
    step();
    chk("rs_after_we", 32'(bus.mem_we_o), 32'd0);
    step();
    chk("rs_after2_we",   32'(bus.mem_we_o), 32'd0);
    chk("rs_after2_busy", 32'(bus.busy_o),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
